dram_fetch_to_swizzle: RTL and testbench

//  Upstream feeder of the DRAM-to-CRAM swizzle stage. On a start command it issues NUM read requests
//  to the memory controller from a base address, absorbs responses in a credit-protected FIFO, and

---
 rtl/dram_fetch_to_swizzle_pkg.sv | 20 ++
 rtl/dram_fetch_to_swizzle_fetch_rsp_fifo.sv | 60 ++++++
 rtl/dram_fetch_to_swizzle.sv | 176 +++++++++++++++++
 tb/tb_dram_fetch_to_swizzle.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_fetch_to_swizzle_pkg.sv
// Shared definitions for the DRAM fetch front end of the swizzle path.
// Contents:
//   DEF_*          default widths and depths used by the fetch block and its FIFO
//   fetch_state_t  fetch controller state encoding
package dram_fetch_pkg;

  localparam int DEF_MEM_CTRL_DWIDTH = 40;
  localparam int DEF_MEM_CTRL_AWIDTH = 9;
  localparam int DEF_FIFO_DEPTH      = 8;
  localparam int DEF_LOG_FIFO_DEPTH  = 3;
  localparam int DEF_CNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/dram_fetch_to_swizzle_fetch_rsp_fifo.sv
// Response buffer between the memory controller and the output register.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_push_data   write one word
//   i_pop            remove the head word (caller only pops when not empty)
//   o_head           word at the head of the FIFO
//   o_count          number of stored words, 0..DEPTH
//   o_empty          no words stored
// Push while full is legal only together with a pop; the fetch controller's
// credit scheme guarantees that.
module fetch_rsp_fifo
  import dram_fetch_pkg::*;
#(
  parameter int DEPTH     = DEF_FIFO_DEPTH,
  parameter int LOG_DEPTH = DEF_LOG_FIFO_DEPTH,
  parameter int DWIDTH    = DEF_MEM_CTRL_DWIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic [DWIDTH-1:0]    i_push_data,
  input  logic                 i_pop,
  output logic [DWIDTH-1:0]    o_head,
  output logic [LOG_DEPTH:0]   o_count,
  output logic                 o_empty
);

  localparam logic [LOG_DEPTH-1:0] PTR_ONE = 1;
  localparam logic [LOG_DEPTH:0]   CNT_ONE = 1;

  logic [DWIDTH-1:0]    r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/dram_fetch_to_swizzle.sv
// Fetch front end of the DRAM-to-CRAM swizzle stage. A start command issues
// num_words read requests from base_addr, responses are buffered in a
// credit-protected FIFO, and one word per cycle is presented to the swizzle.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start                 command, sampled only in IDLE
//   i_base_addr, i_num_words  transfer description, latched on start
//   o_busy, o_done          transfer in progress / one-cycle completion pulse
//   o_rsp_err               sticky: response seen with nothing outstanding
//   o_mem_req_*, i_mem_req_ready  read request channel
//   i_mem_rsp_valid/_data   in-order read responses, never stalled
//   i_out_ready             downstream accept (tied high for the swizzle)
//   o_data_valid, o_mem_ctrl_data_out  registered output word
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing requests while credit is available
// DRAIN | all requests issued, waiting for responses and output to empty
// DONE  | one-cycle done pulse, then back to IDLE
module dram_fetch_to_swizzle
  import dram_fetch_pkg::*;
#(
  parameter int MEM_CTRL_DWIDTH = DEF_MEM_CTRL_DWIDTH,
  parameter int MEM_CTRL_AWIDTH = DEF_MEM_CTRL_AWIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int LOG_FIFO_DEPTH  = DEF_LOG_FIFO_DEPTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [MEM_CTRL_AWIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]       i_num_words,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_rsp_err,
  output logic                       o_mem_req_valid,
  input  logic                       i_mem_req_ready,
  output logic [MEM_CTRL_AWIDTH-1:0] o_mem_req_addr,
  input  logic                       i_mem_rsp_valid,
  input  logic [MEM_CTRL_DWIDTH-1:0] i_mem_rsp_data,
  input  logic                       i_out_ready,
  output logic                       o_data_valid,
  output logic [MEM_CTRL_DWIDTH-1:0] o_mem_ctrl_data_out
);

  // Wide enough for outstanding + FIFO count + output register at their maxima.
  localparam int SUMW = LOG_FIFO_DEPTH + 2;
  localparam logic [LOG_FIFO_DEPTH:0] OUT_ONE = 1;

  fetch_state_t               r_state;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_rsp_err;
  logic [MEM_CTRL_AWIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]       r_remaining;
  logic [LOG_FIFO_DEPTH:0]    r_outstanding;
  logic                       r_dv;
  logic [MEM_CTRL_DWIDTH-1:0] r_dout;

  logic [MEM_CTRL_DWIDTH-1:0] w_fifo_head;
  logic [LOG_FIFO_DEPTH:0]    w_fifo_count;
  logic                       w_fifo_empty;
  logic [SUMW-1:0]            w_credit_sum;
  logic                       w_req_valid;
  logic                       w_req_hs;
  logic                       w_rsp_ok;
  logic                       w_rsp_stray;
  logic                       w_pop;
  logic                       w_start_acc;

  // Every issued request owns a slot in the FIFO or the output register, so a
  // response can always be written. The sum only falls while a request waits,
  // which keeps mem_req_valid from being retracted.
  assign w_credit_sum = SUMW'(r_outstanding) + SUMW'(w_fifo_count) + SUMW'(r_dv);
  assign w_req_valid  = (r_state == ST_FETCH) && (r_remaining != '0) &&
                        (w_credit_sum < SUMW'(FIFO_DEPTH + 1));
  assign w_req_hs     = w_req_valid && i_mem_req_ready;
  assign w_rsp_ok     = i_mem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_stray  = i_mem_rsp_valid && (r_outstanding == '0);
  assign w_pop        = !w_fifo_empty && (!r_dv || i_out_ready);
  assign w_start_acc  = i_start && (r_state == ST_IDLE);

  fetch_rsp_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .LOG_DEPTH (LOG_FIFO_DEPTH),
    .DWIDTH    (MEM_CTRL_DWIDTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_rsp_ok),
    .i_push_data (i_mem_rsp_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_num_words;
            if (i_num_words != '0) begin
              r_state <= ST_FETCH;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          if (w_req_hs) begin
            r_addr      <= r_addr + MEM_CTRL_AWIDTH'(1);
            r_remaining <= r_remaining - CNT_WIDTH'(1);
          end
          if (r_remaining == '0) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((r_outstanding == '0) && w_fifo_empty && !r_dv) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_outstanding <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_req_hs && !w_rsp_ok)      r_outstanding <= r_outstanding + OUT_ONE;
      else if (!w_req_hs && w_rsp_ok) r_outstanding <= r_outstanding - OUT_ONE;

      if (w_start_acc)      r_rsp_err <= w_rsp_stray;
      else if (w_rsp_stray) r_rsp_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dv   <= 1'b0;
      r_dout <= '0;
    end else if (w_pop) begin
      r_dv   <= 1'b1;
      r_dout <= w_fifo_head;
    end else if (i_out_ready) begin
      r_dv   <= 1'b0;
    end
  end

  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_rsp_err           = r_rsp_err;
  assign o_mem_req_valid     = w_req_valid;
  assign o_mem_req_addr      = r_addr;
  assign o_data_valid        = r_dv;
  assign o_mem_ctrl_data_out = r_dout;

endmodule

// File: tb/tb_dram_fetch_to_swizzle.sv
// Bench for dram_fetch_to_swizzle: a memory-controller model answers requests
// from a random memory image; received words are checked against the image
// contents at base+i (mod 2^AW).
module tb_dram_fetch_to_swizzle;
  localparam int DW = 40;
  localparam int AW = 9;
  localparam int CW = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] num = '0;
  logic          busy, done, rsp_err, req_valid;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic          out_ready = 1'b0;
  logic          data_valid;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  dram_fetch_to_swizzle dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base), .i_num_words(num),
    .o_busy(busy), .o_done(done), .o_rsp_err(rsp_err),
    .o_mem_req_valid(req_valid), .i_mem_req_ready(req_ready), .o_mem_req_addr(req_addr),
    .i_mem_rsp_valid(rsp_valid), .i_mem_rsp_data(rsp_data),
    .i_out_ready(out_ready), .o_data_valid(data_valid), .o_mem_ctrl_data_out(dout)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem_img [1 << AW];

  // bus model configuration
  int cfg_lat = 3;
  bit cfg_lat_rand = 1'b0;
  bit cfg_ready_rand = 1'b0;
  int cfg_req_limit = 1 << 30;
  bit cfg_out_rand = 1'b0;
  bit cfg_out_ready = 1'b1;

  // observations
  int cyc = 0, n_req = 0, n_out = 0, done_cnt = 0, done_cyc = -1, stall_viol = 0;
  int max_inflight = 0, first_rsp_cyc = -1, first_dv_cyc = -1, last_dv_cyc = -1;
  int dv_cycles = 0, req_seen = 0;
  logic [AW-1:0] req_addr_q[$];
  logic [DW-1:0] got_q[$];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t rsp_q[$];
  int   last_due = 0;
  int   m_lat, m_due;
  bit   stall_prev = 1'b0;
  logic [AW-1:0] stall_addr = '0;

  // Memory controller + downstream model: inputs change on the falling edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    req_ready = (cfg_ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1) && (n_req < cfg_req_limit);
    out_ready = cfg_out_rand ? ($urandom_range(0, 1) == 1) : cfg_out_ready;
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev && (!req_valid || req_addr !== stall_addr)) stall_viol++;
      stall_prev = req_valid && !req_ready;
      stall_addr = req_addr;
    end
    if (req_valid) req_seen++;
    if (req_valid && req_ready) begin
      req_addr_q.push_back(req_addr);
      n_req++;
      m_lat = cfg_lat_rand ? int'($urandom_range(1, 6)) : cfg_lat;
      m_due = cyc + m_lat;
      if (m_due <= last_due) m_due = last_due + 1;
      last_due = m_due;
      rsp_q.push_back('{m_due, mem_img[req_addr]});
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = rsp_q[0].data;
      void'(rsp_q.pop_front());
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = DW'({$urandom(), $urandom()});
    end
    if (data_valid && out_ready) begin
      got_q.push_back(dout);
      n_out++;
    end
    if (data_valid) begin
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      last_dv_cyc = cyc;
      dv_cycles++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (n_req - n_out > max_inflight) max_inflight = n_req - n_out;
  end

  task automatic clear_obs();
    n_req = 0; n_out = 0; done_cnt = 0; done_cyc = -1; stall_viol = 0; max_inflight = 0;
    first_rsp_cyc = -1; first_dv_cyc = -1; last_dv_cyc = -1; dv_cycles = 0; req_seen = 0;
    req_addr_q.delete();
    got_q.delete();
  endtask

  task automatic start_xfer(input int b, input int n);
    @(posedge clk); #1;
    clear_obs();
    start = 1'b1; base = AW'(b); num = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, input int budget);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
    n_vec++; if (req_addr !== '0) begin n_err++; $display("FAIL reset_req_addr got %h exp 0", req_addr); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got %b exp 0", data_valid); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_data_out got %h exp 0", dout); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    logic [AW-1:0] ea;
    cfg_lat = 3; cfg_lat_rand = 0; cfg_ready_rand = 0; cfg_out_rand = 0; cfg_out_ready = 1;
    start_xfer(32'h010, 5);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_done(ok, 200);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout got 0 exp 1"); end
    n_vec++; if (n_req !== 5) begin n_err++; $display("FAIL basic_nreq got %0d exp 5", n_req); end
    for (int i = 0; i < req_addr_q.size() && i < 5; i++) begin
      ea = AW'(32'h010 + i);
      n_vec++; if (req_addr_q[i] !== ea) begin n_err++; $display("FAIL basic_addr%0d got %h exp %h", i, req_addr_q[i], ea); end
    end
    n_vec++; if (got_q.size() !== 5) begin n_err++; $display("FAIL basic_nwords got %0d exp 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_vec++; if (got_q[i] !== mem_img[AW'(32'h010 + i)]) begin n_err++; $display("FAIL basic_data%0d got %h exp %h", i, got_q[i], mem_img[AW'(32'h010 + i)]); end
    end
    n_vec++; if (dv_cycles !== 5) begin n_err++; $display("FAIL basic_dv_cycles got %0d exp 5", dv_cycles); end
    n_vec++; if (last_dv_cyc - first_dv_cyc + 1 !== 5) begin n_err++; $display("FAIL basic_dv_contig got %0d exp 5", last_dv_cyc - first_dv_cyc + 1); end
    n_vec++; if (first_dv_cyc - first_rsp_cyc !== 2) begin n_err++; $display("FAIL basic_rsp_latency got %0d exp 2", first_dv_cyc - first_rsp_cyc); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
    n_vec++; if (!(done_cyc > last_dv_cyc)) begin n_err++; $display("FAIL basic_done_after_data got %0d exp >%0d", done_cyc, last_dv_cyc); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] ea;
    start_xfer(32'h1FE, 4);
    wait_done(ok, 200);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_done_timeout got 0 exp 1"); end
    n_vec++; if (req_addr_q.size() !== 4) begin n_err++; $display("FAIL wrap_nreq got %0d exp 4", req_addr_q.size()); end
    for (int i = 0; i < req_addr_q.size() && i < 4; i++) begin
      ea = AW'((32'h1FE + i) % 512);
      n_vec++; if (req_addr_q[i] !== ea) begin n_err++; $display("FAIL wrap_addr%0d got %h exp %h", i, req_addr_q[i], ea); end
    end
    n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL wrap_nwords got %0d exp 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_vec++; if (got_q[i] !== mem_img[(32'h1FE + i) % 512]) begin n_err++; $display("FAIL wrap_data%0d got %h exp %h", i, got_q[i], mem_img[(32'h1FE + i) % 512]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    cfg_out_ready = 0;
    start_xfer(32'h080, 20);
    repeat (30) @(posedge clk);
    #1;
    n_vec++; if (n_out !== 0) begin n_err++; $display("FAIL bp_words_while_stalled got %0d exp 0", n_out); end
    n_vec++; if (n_req !== DEPTH + 1) begin n_err++; $display("FAIL bp_reqs_while_stalled got %0d exp %0d", n_req, DEPTH + 1); end
    n_vec++; if (max_inflight !== DEPTH + 1) begin n_err++; $display("FAIL bp_max_inflight got %0d exp %0d", max_inflight, DEPTH + 1); end
    n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL bp_data_valid_held got %b exp 1", data_valid); end
    cfg_out_ready = 1;
    wait_done(ok, 300);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout got 0 exp 1"); end
    n_vec++; if (got_q.size() !== 20) begin n_err++; $display("FAIL bp_nwords got %0d exp 20", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 20; i++) begin
      n_vec++; if (got_q[i] !== mem_img[32'h080 + i]) begin n_err++; $display("FAIL bp_data%0d got %h exp %h", i, got_q[i], mem_img[32'h080 + i]); end
    end
    n_vec++; if (max_inflight > DEPTH + 1) begin n_err++; $display("FAIL bp_inflight_bound got %0d exp <=%0d", max_inflight, DEPTH + 1); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1;
    clear_obs();
    start = 1'b1; base = AW'(32'h033); num = '0;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_early got %b exp 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy1 got %b exp 0", busy); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_pulse got %b exp 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy2 got %b exp 0", busy); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width got %b exp 0", done); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (req_seen !== 0) begin n_err++; $display("FAIL zero_req_valid got %0d exp 0", req_seen); end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    cfg_lat = 10;
    cfg_req_limit = 3;
    start_xfer(32'h040, 10);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (n_req >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec++; if (!reached) begin n_err++; $display("FAIL rmid_three_reqs got %0d exp 3", n_req); end
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b exp 0", done); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rmid_rsp_err got %b exp 0", rsp_err); end
    n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rmid_req_valid got %b exp 0", req_valid); end
    n_vec++; if (req_addr !== '0) begin n_err++; $display("FAIL rmid_req_addr got %h exp 0", req_addr); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rmid_data_valid got %b exp 0", data_valid); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL rmid_data_out got %h exp 0", dout); end
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_req_limit = 1 << 30;
    @(posedge clk); #1;
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rmid_rsp_err_before_late got %b exp 0", rsp_err); end
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (rsp_q.size() !== 0) begin n_err++; $display("FAIL rmid_late_rsps_sent got %0d exp 0", rsp_q.size()); end
    n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL rmid_rsp_err_late got %b exp 1", rsp_err); end
    n_vec++; if (dv_cycles !== 0) begin n_err++; $display("FAIL rmid_late_data got %0d exp 0", dv_cycles); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy_idle got %b exp 0", busy); end
    cfg_lat = 3;
  endtask

  task automatic test_random_ready();
    bit ok;
    int b;
    logic [AW-1:0] ea;
    b = int'($urandom_range(0, 511));
    cfg_ready_rand = 1; cfg_lat_rand = 1;
    start_xfer(b, 16);
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rr_rsp_err_cleared got %b exp 0", rsp_err); end
    wait_done(ok, 600);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_done_timeout got 0 exp 1"); end
    n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL rr_req_stable got %0d exp 0", stall_viol); end
    n_vec++; if (req_addr_q.size() !== 16) begin n_err++; $display("FAIL rr_nreq got %0d exp 16", req_addr_q.size()); end
    for (int i = 0; i < req_addr_q.size() && i < 16; i++) begin
      ea = AW'((b + i) % 512);
      n_vec++; if (req_addr_q[i] !== ea) begin n_err++; $display("FAIL rr_addr%0d got %h exp %h", i, req_addr_q[i], ea); end
    end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL rr_nwords got %0d exp 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      n_vec++; if (got_q[i] !== mem_img[(b + i) % 512]) begin n_err++; $display("FAIL rr_data%0d got %h exp %h", i, got_q[i], mem_img[(b + i) % 512]); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL rr_done_count got %0d exp 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int b, n;
    cfg_ready_rand = 1; cfg_lat_rand = 1; cfg_out_rand = 1;
    for (int t = 0; t < 4; t++) begin
      b = int'($urandom_range(0, 511));
      n = int'($urandom_range(1, 24));
      start_xfer(b, n);
      if (t == 0) begin
        // a second command while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; base = '0; num = CW'(3);
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(ok, 1500);
      n_vec++; if (!ok) begin n_err++; $display("FAIL b2b%0d_done_timeout got 0 exp 1", t); end
      n_vec++; if (got_q.size() !== n) begin n_err++; $display("FAIL b2b%0d_nwords got %0d exp %0d", t, got_q.size(), n); end
      for (int i = 0; i < got_q.size() && i < n; i++) begin
        n_vec++; if (got_q[i] !== mem_img[(b + i) % 512]) begin n_err++; $display("FAIL b2b%0d_data%0d got %h exp %h", t, i, got_q[i], mem_img[(b + i) % 512]); end
      end
      n_vec++; if (stall_viol !== 0) begin n_err++; $display("FAIL b2b%0d_req_stable got %0d exp 0", t, stall_viol); end
      n_vec++; if (max_inflight > DEPTH + 1) begin n_err++; $display("FAIL b2b%0d_inflight got %0d exp <=%0d", t, max_inflight, DEPTH + 1); end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL b2b%0d_done_count got %0d exp 1", t, done_cnt); end
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL b2b%0d_rsp_err got %b exp 0", t, rsp_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_img[i] = DW'({$urandom(), $urandom()});
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_random_ready();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
